// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - programmable SPI SCLK generator with CPOL/CPHA, burst length and strobes
// Optional feature macro: SPI_SCLK_GEN_ABORT_EN (adds abort_i / aborted_o)
module spi_sclk_gen #(
  parameter int CNT_W  = 16,
  parameter int BITS_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  div_i,
  input  logic [BITS_W-1:0] nbits_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
`ifdef SPI_SCLK_GEN_ABORT_EN
  input  logic              abort_i,
  output logic              aborted_o,
`endif
  output logic              sclk_o,
  output logic              sample_stb_o,
  output logic              shift_stb_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  half_cnt;
  logic [BITS_W:0]   edge_cnt;
  logic [CNT_W-1:0]  div_l;
  logic              cpol_l;
  logic              cpha_l;
  logic              lead;
  logic              abort_req;

  // An even remaining-edge count means the next toggle is an odd (leading) edge
  assign lead = ~edge_cnt[0];

`ifdef SPI_SCLK_GEN_ABORT_EN
  assign abort_req = abort_i && (state != ST_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Main sequencer: half-period timing, SCLK toggling, edge counting and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      half_cnt     <= '0;
      edge_cnt     <= '0;
      div_l        <= '0;
      cpol_l       <= 1'b0;
      cpha_l       <= 1'b0;
      sclk_o       <= 1'b0;
      sample_stb_o <= 1'b0;
      shift_stb_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef SPI_SCLK_GEN_ABORT_EN
      aborted_o    <= 1'b0;
`endif
    end else begin
      sample_stb_o <= 1'b0;
      shift_stb_o  <= 1'b0;
      done_o       <= 1'b0;
`ifdef SPI_SCLK_GEN_ABORT_EN
      aborted_o    <= 1'b0;
`endif
      if (abort_req) begin
        // Abort takes priority over any edge due this cycle
        state  <= ST_IDLE;
        busy_o <= 1'b0;
        sclk_o <= cpol_l;
`ifdef SPI_SCLK_GEN_ABORT_EN
        aborted_o <= 1'b1;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            sclk_o <= cpol_i;
            if (start_i && (nbits_i != '0)) begin
              div_l    <= div_i;
              cpol_l   <= cpol_i;
              cpha_l   <= cpha_i;
              half_cnt <= div_i;
              edge_cnt <= {nbits_i, 1'b0};
              busy_o   <= 1'b1;
              state    <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (half_cnt == '0) begin
              half_cnt     <= div_l;
              sclk_o       <= ~sclk_o;
              edge_cnt     <= edge_cnt - 1'b1;
              sample_stb_o <= lead ^ cpha_l;
              shift_stb_o  <= ~(lead ^ cpha_l);
              if (edge_cnt == {{BITS_W{1'b0}}, 1'b1}) begin
                state <= ST_TAIL;
              end
            end else begin
              half_cnt <= half_cnt - 1'b1;
            end
          end
          ST_TAIL: begin
            // Hold guard of one half-period before releasing the bus
            if (half_cnt == '0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              half_cnt <= half_cnt - 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - randomized self-checking bench for spi_sclk_gen
module tb_spi_sclk_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cpol, cpha;
  logic [15:0] div;
  logic [5:0]  nbits;
  logic        sclk, samp, shft, busy, done;
`ifdef SPI_SCLK_GEN_ABORT_EN
  logic        abort, aborted, b_aborted;
`endif
  logic        b_start;
  logic [7:0]  b_div;
  logic [5:0]  b_nbits;
  logic        b_sclk, b_samp, b_shft, b_busy, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state (transfer-level timeline)
  bit m_busy;
  int m_t, m_h, m_n;
  bit m_cpol, m_cpha;
  bit e_sclk, e_samp, e_shft, e_busy, e_done, e_abt;

  always #5 clk = ~clk;

  spi_sclk_gen #(.CNT_W(16), .BITS_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start), .div_i(div), .nbits_i(nbits),
    .cpol_i(cpol), .cpha_i(cpha),
`ifdef SPI_SCLK_GEN_ABORT_EN
    .abort_i(abort), .aborted_o(aborted),
`endif
    .sclk_o(sclk), .sample_stb_o(samp), .shift_stb_o(shft), .busy_o(busy), .done_o(done)
  );

  spi_sclk_gen #(.CNT_W(8), .BITS_W(6)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .div_i(b_div), .nbits_i(b_nbits),
    .cpol_i(1'b0), .cpha_i(1'b0),
`ifdef SPI_SCLK_GEN_ABORT_EN
    .abort_i(1'b0), .aborted_o(b_aborted),
`endif
    .sclk_o(b_sclk), .sample_stb_o(b_samp), .shift_stb_o(b_shft), .busy_o(b_busy), .done_o(b_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Edge j of a transfer lands j half-periods after busy rises; done one more after the last.
  task automatic model();
    int j;
    e_samp = 0; e_shft = 0; e_done = 0; e_abt = 0;
    if (rst) begin
      m_busy = 0; e_sclk = 0; e_busy = 0;
    end else if (!m_busy) begin
      e_sclk = cpol; e_busy = 0;
      if (start && nbits != 0) begin
        m_busy = 1; m_t = 0; m_h = int'(div) + 1; m_n = int'(nbits);
        m_cpol = cpol; m_cpha = cpha; e_busy = 1;
      end
`ifdef SPI_SCLK_GEN_ABORT_EN
    end else if (abort) begin
      m_busy = 0; e_busy = 0; e_sclk = m_cpol; e_abt = 1;
`endif
    end else begin
      m_t++;
      if (m_t == (2 * m_n + 1) * m_h) begin
        m_busy = 0; e_busy = 0; e_done = 1; e_sclk = m_cpol;
      end else if (m_t % m_h == 0 && m_t <= 2 * m_n * m_h) begin
        j = m_t / m_h;
        e_sclk = m_cpol ^ (j % 2 == 1);
        e_samp = (j % 2 == 1) ^ m_cpha;
        e_shft = !e_samp;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model();
    check("sclk", sclk, e_sclk);
    check("sample_stb", samp, e_samp);
    check("shift_stb", shft, e_shft);
    check("busy", busy, e_busy);
    check("done", done, e_done);
`ifdef SPI_SCLK_GEN_ABORT_EN
    check("aborted", aborted, e_abt);
`endif
  endtask

  task automatic xfer(input int d, input int n, input bit pol, input bit pha);
    int k, ns, nh;
    div = 16'(d); nbits = 6'(n); cpol = pol; cpha = pha; start = 1;
    step();
    start = 0;
    div = 16'($urandom); nbits = 6'($urandom); cpol = ~pol; cpha = ~pha;
    k = 0; ns = 0; nh = 0;
    while (!done && k < 5000) begin
      step();
      k++;
      ns += int'(samp); nh += int'(shft);
    end
    check("xfer_len", k, (2 * n + 1) * (d + 1));
    check("xfer_samples", ns, n);
    check("xfer_shifts", nh, n);
    cpol = pol;
  endtask

  task automatic wait_strobes(input int cnt);
    int k, s;
    k = 0; s = 0;
    while (s < cnt && k < 2000) begin
      step();
      k++;
      s += int'(samp | shft);
    end
    check("strobe_wait", s, cnt);
  endtask

  initial begin
    int k, ne;
    rst = 1; start = 0; cpol = 0; cpha = 0; div = 0; nbits = 0;
    b_start = 0; b_div = 8'hFF; b_nbits = 6'd1;
`ifdef SPI_SCLK_GEN_ABORT_EN
    abort = 0;
`endif
    m_busy = 0; e_sclk = 0;
    #1;
    check("reset_sclk", sclk, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    step(); step();
    rst = 0;
    step();

    // directed transfers, including the documented timing cases and max burst length
    xfer(3, 8, 0, 0);
    xfer(0, 1, 1, 1);
    xfer(5, 3, 1, 0);
    xfer(2, 63, 0, 1);
    xfer(0, 5, 0, 1);

    // start held high: back-to-back transfers, mid-transfer starts ignored
    div = 1; nbits = 2; cpol = 0; cpha = 0; start = 1;
    repeat (45) step();
    // zero-length request is ignored
    start = 0;
    while (busy) step();
    nbits = 0; start = 1;
    repeat (6) step();
    start = 0;
    step();

    // reset in the middle of a transfer
    div = 1; nbits = 8; cpol = 0; cpha = 0; start = 1;
    step();
    start = 0;
    wait_strobes(5);
    rst = 1;
    #1;
    check("midrst_sclk", sclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_stb", samp | shft, 0);
    check("midrst_done", done, 0);
    m_busy = 0; e_sclk = 0;
    step(); step();
    rst = 0;
    step();
    xfer(1, 2, 0, 0);

    // maximum divisor on the narrow-counter instance: no wrap
    b_start = 1;
    step();
    b_start = 0;
    check("b_busy", b_busy, 1);
    k = 0; ne = 0;
    while (!b_done && k < 2000) begin
      step();
      k++;
      ne += int'(b_samp | b_shft);
    end
    check("b_len", k, 768);
    check("b_edges", ne, 2);

`ifdef SPI_SCLK_GEN_ABORT_EN
    div = 1; nbits = 8; cpol = 1; cpha = 0; start = 1;
    step();
    start = 0;
    wait_strobes(3);
    abort = 1;
    step();
    abort = 0;
    check("abort_pulse", aborted, 1);
    check("abort_sclk", sclk, 1);
    repeat (20) step();
`endif

    // randomized traffic
    for (int i = 0; i < 20000; i++) begin
      start = ($urandom % 3 == 0);
      div   = 16'($urandom % 5);
      nbits = 6'($urandom % 6);
      cpol  = 1'($urandom);
      cpha  = 1'($urandom);
      rst   = ($urandom % 3000 == 0);
`ifdef SPI_SCLK_GEN_ABORT_EN
      abort = ($urandom % 150 == 0);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
